// File: rtl/ddr_luma_line_fetch_pkg.sv
// rtl/ddr_luma_line_fetch_pkg.sv - shared FMV constants, FSM state and DDR address types
package ddr_luma_line_fetch_pkg;

  localparam int LUMA_MAX_WIDTH = 640;
  localparam int LUMA_MAX_WORDS = (LUMA_MAX_WIDTH + 7) / 8;
  localparam int WORDS_W        = $clog2(LUMA_MAX_WORDS + 1);
  localparam int DDR_ADDR_W     = 28;

  typedef logic [DDR_ADDR_W-1:0] ddr_word_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_REQ,
    ST_DATA,
    ST_DONE
  } fetch_state_e;

  // Eight 8-bit pixels per 64-bit word, partial last word rounds up.
  function automatic logic [WORDS_W-1:0] luma_words(input logic [9:0] width);
    logic [10:0] sum;
    sum = {1'b0, width} + 11'd7;
    return WORDS_W'(sum >> 3);
  endfunction

endpackage

// File: rtl/ddr_luma_line_fetch_if.sv
// rtl/ddr_luma_line_fetch_if.sv - DDR burst read port between the line fetcher and memory
interface ddr_luma_line_fetch_if #(
  parameter int ADDR_W    = 28,
  parameter int BURST_MAX = 16
);
  localparam int BC_W = $clog2(BURST_MAX) + 1;

  logic              ddr_rd;
  logic [ADDR_W-1:0] ddr_addr;
  logic [BC_W-1:0]   ddr_burstcnt;
  logic              ddr_busy;
  logic [63:0]       ddr_rdata;
  logic              ddr_rdata_valid;

  modport master (
    output ddr_rd, ddr_addr, ddr_burstcnt,
    input  ddr_busy, ddr_rdata, ddr_rdata_valid
  );

  modport slave (
    input  ddr_rd, ddr_addr, ddr_burstcnt,
    output ddr_busy, ddr_rdata, ddr_rdata_valid
  );

endinterface

// File: rtl/ddr_burst_splitter.sv
// rtl/ddr_burst_splitter.sv - tracks words issued for a line and sizes the next DDR burst
module ddr_burst_splitter
  import ddr_luma_line_fetch_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int BURST_MAX = 16,
  parameter int BC_W      = $clog2(BURST_MAX) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [ADDR_W-1:0]  line_addr,
  input  logic [WORDS_W-1:0] words,
  input  logic               accept,
  output logic [BC_W-1:0]    burstcnt,
  output logic [ADDR_W-1:0]  burst_addr,
  output logic               last_burst
);

  logic [ADDR_W-1:0]  base_q;
  logic [WORDS_W-1:0] words_q;
  logic [WORDS_W-1:0] issued_q;
  logic [WORDS_W-1:0] remain;

  assign remain     = words_q - issued_q;
  assign burst_addr = base_q + ADDR_W'(issued_q);
  // issued advances at request acceptance, so during DATA this says the
  // burst in flight was the final one.
  assign last_burst = (issued_q >= words_q);

  always_comb begin
    burstcnt = BC_W'(remain);
    if (remain > WORDS_W'(BURST_MAX)) begin
      burstcnt = BC_W'(BURST_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      words_q  <= '0;
      issued_q <= '0;
    end else if (load) begin
      base_q   <= line_addr;
      words_q  <= words;
      issued_q <= '0;
    end else if (accept) begin
      issued_q <= issued_q + WORDS_W'(burstcnt);
    end
  end

endmodule

// File: rtl/ddr_luma_line_fetch.sv
// rtl/ddr_luma_line_fetch.sv - fetches one luma line from DDR in bounded bursts into the line buffer
module ddr_luma_line_fetch
  import ddr_luma_line_fetch_pkg::*;
#(
  parameter int ADDR_W    = DDR_ADDR_W,
  parameter int BURST_MAX = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           frame_base,
  input  logic [8:0]                  line_num,
  input  logic [7:0]                  stride,
  input  logic [9:0]                  width,
  output logic                        busy,
  output logic                        done,
  ddr_luma_line_fetch_if.master       ddr,
  output logic                        lb_clear,
  output logic [63:0]                 lb_wdata,
  output logic                        lb_we
);

  localparam int BC_W = $clog2(BURST_MAX) + 1;

  fetch_state_e state, state_nxt;

  logic [ADDR_W-1:0]  base_q;
  logic [8:0]         line_q;
  logic [7:0]         stride_q;
  logic [9:0]         width_q;
  logic [16:0]        line_off;
  logic [ADDR_W-1:0]  line_addr;
  logic [WORDS_W-1:0] words;
  logic [BC_W-1:0]    burstcnt;
  logic [ADDR_W-1:0]  burst_addr;
  logic               last_burst;
  logic [BC_W-1:0]    beat_cnt;
  logic [BC_W-1:0]    cur_len;
  logic               accept;
  logic               take_beat;
  logic               final_beat;

  assign line_off  = 17'(line_q) * 17'(stride_q);
  assign line_addr = base_q + ADDR_W'(line_off);
  assign words     = luma_words(width_q);

  assign accept     = (state == ST_REQ) && !ddr.ddr_busy;
  assign take_beat  = (state == ST_DATA) && ddr.ddr_rdata_valid && (beat_cnt != cur_len);
  assign final_beat = take_beat && (beat_cnt == cur_len - BC_W'(1));

  ddr_burst_splitter #(
    .ADDR_W    (ADDR_W),
    .BURST_MAX (BURST_MAX),
    .BC_W      (BC_W)
  ) u_splitter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (state == ST_CLEAR),
    .line_addr  (line_addr),
    .words      (words),
    .accept     (accept),
    .burstcnt   (burstcnt),
    .burst_addr (burst_addr),
    .last_burst (last_burst)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // After the final beat of the last burst the FSM lingers one cycle in
  // DATA so done lands on the cycle after the registered last write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (words == '0) ? ST_DONE : ST_REQ;
      ST_REQ:   if (!ddr.ddr_busy) state_nxt = ST_DATA;
      ST_DATA: begin
        if (final_beat) begin
          if (!last_burst) state_nxt = ST_REQ;
        end else if (beat_cnt == cur_len) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      line_q   <= '0;
      stride_q <= '0;
      width_q  <= '0;
      beat_cnt <= '0;
      cur_len  <= '0;
      lb_we    <= 1'b0;
      lb_wdata <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        base_q   <= frame_base;
        line_q   <= line_num;
        stride_q <= stride;
        width_q  <= width;
      end
      if (accept) begin
        beat_cnt <= '0;
        cur_len  <= burstcnt;
      end else if (take_beat) begin
        beat_cnt <= beat_cnt + BC_W'(1);
      end
      lb_we <= take_beat;
      if (take_beat) begin
        lb_wdata <= ddr.ddr_rdata;
      end
    end
  end

  assign busy             = (state != ST_IDLE);
  assign done             = (state == ST_DONE);
  assign lb_clear         = (state == ST_CLEAR);
  assign ddr.ddr_rd       = (state == ST_REQ);
  assign ddr.ddr_addr     = (state == ST_REQ) ? burst_addr : '0;
  assign ddr.ddr_burstcnt = (state == ST_REQ) ? burstcnt : '0;

endmodule

// File: tb/tb_ddr_luma_line_fetch.sv
// tb/tb_ddr_luma_line_fetch.sv - directed self-checking bench for ddr_luma_line_fetch
module tb_ddr_luma_line_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] frame_base = '0;
  logic [8:0]  line_num = '0;
  logic [7:0]  stride = '0;
  logic [9:0]  width = '0;
  logic        busy, done, lb_clear, lb_we;
  logic [63:0] lb_wdata;

  ddr_luma_line_fetch_if #(.ADDR_W(28), .BURST_MAX(16)) ddr_if ();

  ddr_luma_line_fetch #(.ADDR_W(28), .BURST_MAX(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .frame_base (frame_base),
    .line_num   (line_num),
    .stride     (stride),
    .width      (width),
    .busy       (busy),
    .done       (done),
    .ddr        (ddr_if),
    .lb_clear   (lb_clear),
    .lb_wdata   (lb_wdata),
    .lb_we      (lb_we)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_cnt = 0, done_cnt = 0, clr_cnt = 0, rd_cnt = 0;
  int last_we_cyc = 0, done_cyc = 0;
  logic [63:0] got[$];
  logic [27:0] req_addr[$];
  logic [4:0]  req_len[$];
  logic [27:0] pend[$];

  function automatic logic [63:0] mem_word(input logic [27:0] a);
    return {32'hCAFE_0000 ^ {4'h0, a}, 4'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (lb_we) begin
      got.push_back(lb_wdata);
      we_cnt++;
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (lb_clear) clr_cnt++;
    if (ddr_if.ddr_rd) rd_cnt++;
    if (ddr_if.ddr_rd && !ddr_if.ddr_busy) begin
      req_addr.push_back(ddr_if.ddr_addr);
      req_len.push_back(ddr_if.ddr_burstcnt);
    end
  end

  // Zero-latency memory: beats of an accepted burst start the next cycle.
  initial begin
    ddr_if.ddr_rdata_valid = 1'b0;
    ddr_if.ddr_rdata = '0;
    forever begin
      @(negedge clk);
      if (ddr_if.ddr_rd && !ddr_if.ddr_busy)
        for (int i = 0; i < int'(ddr_if.ddr_burstcnt); i++) pend.push_back(ddr_if.ddr_addr + 28'(i));
      @(posedge clk);
      #1;
      if (pend.size() > 0) begin
        ddr_if.ddr_rdata_valid = 1'b1;
        ddr_if.ddr_rdata = mem_word(pend.pop_front());
      end else begin
        ddr_if.ddr_rdata_valid = 1'b0;
      end
    end
  end

  // Returns at cycle T+1 (start sampled at the end of cycle T).
  task automatic kick(input logic [27:0] b, input logic [8:0] l, input logic [7:0] s, input logic [9:0] w);
    @(posedge clk); #1;
    frame_base = b; line_num = l; stride = s; width = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 3000);
    if (done !== 1'b1) chk({tag, "_timeout"}, 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_data(input string tag, input int g0, input logic [27:0] a0, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (g0 + i >= got.size()) errs++;
      else if (got[g0 + i] !== mem_word(a0 + 28'(i))) errs++;
    end
    chk(tag, errs, 0);
  endtask

  int we0, d0, c0, r0, q0, g0, n;
  logic [27:0] a_hold;
  logic [4:0]  l_hold;
  int unstable;
  logic [4:0] exp_len [5] = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd2};

  initial begin
    ddr_if.ddr_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ddr_rd", ddr_if.ddr_rd, 0);
    chk("rst_ddr_addr", ddr_if.ddr_addr, 0);
    chk("rst_burstcnt", ddr_if.ddr_burstcnt, 0);
    chk("rst_lb_clear", lb_clear, 0);
    chk("rst_lb_we", lb_we, 0);
    chk("rst_lb_wdata", lb_wdata, 0);
    reset_n = 1'b1;

    // 384 px, line 2, stride 48, base 0x1000 -> 0x1060, three 16-beat bursts
    we0 = we_cnt; d0 = done_cnt; q0 = req_addr.size(); g0 = got.size();
    kick(28'h1000, 9'd2, 8'd48, 10'd384);
    @(negedge clk);
    chk("t1_busy_t1", busy, 1);
    chk("t1_clear_t1", lb_clear, 1);
    @(negedge clk);
    chk("t1_rd_t2", ddr_if.ddr_rd, 1);
    wait_done("t1");
    chk("t1_nreq", req_addr.size() - q0, 3);
    for (int i = 0; i < 3 && q0 + i < req_addr.size(); i++) begin
      chk($sformatf("t1_addr%0d", i), req_addr[q0 + i], 28'h1060 + 28'(16 * i));
      chk($sformatf("t1_len%0d", i), req_len[q0 + i], 16);
    end
    chk("t1_we", we_cnt - we0, 48);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_done_lag", done_cyc - last_we_cyc, 1);
    check_data("t1_data", g0, 28'h1060, 48);
    chk("t1_busy_after", busy, 0);

    // 528 px -> 66 words: 16,16,16,16,2
    we0 = we_cnt; d0 = done_cnt; q0 = req_addr.size(); g0 = got.size();
    kick(28'h0, 9'd0, 8'd0, 10'd528);
    wait_done("t2");
    chk("t2_nreq", req_addr.size() - q0, 5);
    for (int i = 0; i < 5 && q0 + i < req_addr.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), req_addr[q0 + i], 28'(16 * i));
      chk($sformatf("t2_len%0d", i), req_len[q0 + i], exp_len[i]);
    end
    chk("t2_we", we_cnt - we0, 66);
    chk("t2_done_lag", done_cyc - last_we_cyc, 1);
    check_data("t2_data", g0, 28'h0, 66);

    // 5 px -> one single-beat burst at 0x2000 + 1*3
    we0 = we_cnt; q0 = req_addr.size(); g0 = got.size();
    kick(28'h2000, 9'd1, 8'd3, 10'd5);
    wait_done("t3");
    chk("t3_nreq", req_addr.size() - q0, 1);
    if (req_addr.size() > q0) begin
      chk("t3_addr", req_addr[q0], 28'h2003);
      chk("t3_len", req_len[q0], 1);
    end
    chk("t3_we", we_cnt - we0, 1);
    check_data("t3_data", g0, 28'h2003, 1);

    // width 0: clear at T+1, done at T+2, no read
    r0 = rd_cnt; c0 = clr_cnt; we0 = we_cnt;
    kick(28'h3000, 9'd5, 8'd10, 10'd0);
    @(negedge clk);
    chk("t4_clear_t1", lb_clear, 1);
    @(negedge clk);
    chk("t4_done_t2", done, 1);
    repeat (5) @(negedge clk);
    chk("t4_no_rd", rd_cnt - r0, 0);
    chk("t4_clears", clr_cnt - c0, 1);
    chk("t4_no_we", we_cnt - we0, 0);

    // DDR stalls 7 cycles in REQ; extra starts while busy must be ignored
    ddr_if.ddr_busy = 1'b1;
    we0 = we_cnt; d0 = done_cnt; g0 = got.size();
    kick(28'h300, 9'd4, 8'd10, 10'd64);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ddr_if.ddr_rd !== 1'b1 && n < 20);
    chk("t5_rd_seen", ddr_if.ddr_rd, 1);
    a_hold = ddr_if.ddr_addr;
    l_hold = ddr_if.ddr_burstcnt;
    chk("t5_addr", a_hold, 28'h328);
    chk("t5_len", l_hold, 8);
    unstable = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      start = (k % 2 == 0);
      width = 10'd8;
      frame_base = 28'h7000;
      @(negedge clk);
      if (ddr_if.ddr_rd !== 1'b1 || ddr_if.ddr_addr !== a_hold || ddr_if.ddr_burstcnt !== l_hold) unstable++;
    end
    chk("t5_stable", unstable, 0);
    @(posedge clk); #1;
    start = 1'b0;
    ddr_if.ddr_busy = 1'b0;
    wait_done("t5");
    repeat (20) @(posedge clk);
    #1;
    chk("t5_we", we_cnt - we0, 8);
    check_data("t5_data", g0, 28'h328, 8);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_idle", busy, 0);

    // reset mid-DATA with 5 beats still queued in memory
    kick(28'h500, 9'd0, 8'd0, 10'd128);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pend.size() != 5 && n < 50);
    chk("t6_reached", pend.size(), 5);
    reset_n = 1'b0;
    #1;
    we0 = we_cnt;
    chk("t6_busy", busy, 0);
    chk("t6_ddr_rd", ddr_if.ddr_rd, 0);
    chk("t6_ddr_addr", ddr_if.ddr_addr, 0);
    chk("t6_lb_we", lb_we, 0);
    chk("t6_lb_wdata", lb_wdata, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_stray_we", we_cnt - we0, 0);
    we0 = we_cnt; q0 = req_addr.size(); g0 = got.size();
    kick(28'h40, 9'd0, 8'd0, 10'd16);
    wait_done("t6");
    chk("t6_nreq", req_addr.size() - q0, 1);
    if (req_addr.size() > q0) chk("t6_addr", req_addr[q0], 28'h40);
    chk("t6_we", we_cnt - we0, 2);
    check_data("t6_data", g0, 28'h40, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
